// File: rtl/sar_conv_sequencer_pkg.sv
// Shared types and constants for the SAR conversion sequencer.
package sar_seq_pkg;

    localparam int unsigned SAR_W     = 6;
    localparam int unsigned AVG_N     = 4;
    localparam int unsigned AVG_SHIFT = 2;
    localparam int unsigned ACC_W     = SAR_W + AVG_SHIFT;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SETTLE,
        ST_CONVERT,
        ST_WAIT,
        ST_OUTPUT
    } seq_state_t;

endpackage

// File: rtl/sar_conv_sequencer_if.sv
// Host control, SAR logic and result-stream signals of the sequencer.
interface sar_conv_sequencer_if
    import sar_seq_pkg::*;
#(
    parameter int unsigned NCH = 4
);
    localparam int unsigned CH_W = $clog2(NCH);

    logic             start;
    logic             cont_mode;
    logic             stop;
    logic [NCH-1:0]   ch_mask;
    logic [CH_W-1:0]  mux_sel;
    logic             sh_sample;
    logic             sar_ena;
    logic [SAR_W-1:0] sar_dout;
    logic             sar_done;
    logic             res_valid;
    logic [CH_W-1:0]  res_ch;
    logic [SAR_W-1:0] res_data;
    logic             res_ready;
    logic             busy;
    logic             err;

    // Sequencer side
    modport master (
        input  start, cont_mode, stop, ch_mask, sar_dout, sar_done, res_ready,
        output mux_sel, sh_sample, sar_ena, res_valid, res_ch, res_data, busy, err
    );

    // Host / SAR logic side
    modport slave (
        output start, cont_mode, stop, ch_mask, sar_dout, sar_done, res_ready,
        input  mux_sel, sh_sample, sar_ena, res_valid, res_ch, res_data, busy, err
    );

endinterface

// File: rtl/sar_conv_sequencer_next_ch.sv
// Priority finder: lowest enabled channel at or above the scan pointer.
module sar_next_ch #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CH_W  = $clog2(NCH),
    parameter int unsigned PTR_W = CH_W + 1
) (
    input  logic [NCH-1:0]   mask,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [CH_W-1:0]  ch
);

    // Scan upward; the first hit is the lowest qualifying channel
    always_comb begin
        found = 1'b0;
        ch    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && mask[i] && (PTR_W'(i) >= ptr)) begin
                found = 1'b1;
                ch    = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/sar_conv_sequencer.sv
// Multi-channel scan sequencer for the 6-bit SAR ADC.
// Optional feature macro: SAR_SEQ_AVG_EN (4-sample averaging per channel).
module sar_conv_sequencer
    import sar_seq_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned SETTLE_CYC  = 4,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rest,
    sar_conv_sequencer_if.master  bus
);

    localparam int unsigned CH_W  = $clog2(NCH);
    localparam int unsigned PTR_W = CH_W + 1;
    localparam int unsigned CNT_W = 8;

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [CH_W-1:0]  mux_sel_r, mux_nxt;
    logic [CH_W-1:0]  res_ch_r, rch_nxt;
    logic [SAR_W-1:0] res_data_r, rdata_nxt;
    logic             err_r, err_nxt;
    logic             stop_r, stop_nxt;
    logic [NCH-1:0]   mask_r, mask_nxt;
    logic             cont_r, cont_nxt;
    logic             found;
    logic [CH_W-1:0]  found_ch;

`ifdef SAR_SEQ_AVG_EN
    localparam int unsigned IDX_W = $clog2(AVG_N);
    logic [ACC_W-1:0] acc, acc_nxt, acc_sum;
    logic [IDX_W-1:0] idx, idx_nxt;
`endif

    sar_next_ch #(
        .NCH   (NCH),
        .CH_W  (CH_W),
        .PTR_W (PTR_W)
    ) u_next_ch (
        .mask  (mask_r),
        .ptr   (ptr),
        .found (found),
        .ch    (found_ch)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rest) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state and datapath next values; every register holds by default
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        mux_nxt   = mux_sel_r;
        rch_nxt   = res_ch_r;
        rdata_nxt = res_data_r;
        err_nxt   = err_r;
        mask_nxt  = mask_r;
        cont_nxt  = cont_r;
        stop_nxt  = stop_r | ((state != ST_IDLE) && bus.stop);
`ifdef SAR_SEQ_AVG_EN
        acc_nxt   = acc;
        idx_nxt   = idx;
        acc_sum   = acc + ACC_W'(bus.sar_dout);
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start && (bus.ch_mask != '0)) begin
                    mask_nxt  = bus.ch_mask;
                    cont_nxt  = bus.cont_mode;
                    ptr_nxt   = '0;
                    err_nxt   = 1'b0;
                    stop_nxt  = 1'b0;
                    state_nxt = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (stop_r) begin
                    state_nxt = ST_IDLE;
                end else if (found) begin
                    mux_nxt   = found_ch;
                    cnt_nxt   = '0;
`ifdef SAR_SEQ_AVG_EN
                    acc_nxt   = '0;
                    idx_nxt   = '0;
`endif
                    state_nxt = ST_SETTLE;
                end else if (cont_r) begin
                    ptr_nxt   = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_CONVERT;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.sar_done) begin
`ifdef SAR_SEQ_AVG_EN
                    // Intermediate samples loop back to SETTLE without reselecting
                    if (idx == IDX_W'(AVG_N - 1)) begin
                        rdata_nxt = acc_sum[AVG_SHIFT +: SAR_W];
                        rch_nxt   = mux_sel_r;
                        state_nxt = ST_OUTPUT;
                    end else begin
                        acc_nxt   = acc_sum;
                        idx_nxt   = idx + IDX_W'(1);
                        cnt_nxt   = '0;
                        state_nxt = ST_SETTLE;
                    end
`else
                    rdata_nxt = bus.sar_dout;
                    rch_nxt   = mux_sel_r;
                    state_nxt = ST_OUTPUT;
`endif
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_nxt   = 1'b1;
                    ptr_nxt   = PTR_W'(mux_sel_r) + PTR_W'(1);
                    state_nxt = ST_SELECT;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (bus.res_ready) begin
                    ptr_nxt   = PTR_W'(mux_sel_r) + PTR_W'(1);
                    state_nxt = ST_SELECT;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rest) begin
            cnt        <= '0;
            ptr        <= '0;
            mux_sel_r  <= '0;
            res_ch_r   <= '0;
            res_data_r <= '0;
            err_r      <= 1'b0;
            stop_r     <= 1'b0;
            mask_r     <= '0;
            cont_r     <= 1'b0;
`ifdef SAR_SEQ_AVG_EN
            acc        <= '0;
            idx        <= '0;
`endif
        end else begin
            cnt        <= cnt_nxt;
            ptr        <= ptr_nxt;
            mux_sel_r  <= mux_nxt;
            res_ch_r   <= rch_nxt;
            res_data_r <= rdata_nxt;
            err_r      <= err_nxt;
            stop_r     <= stop_nxt;
            mask_r     <= mask_nxt;
            cont_r     <= cont_nxt;
`ifdef SAR_SEQ_AVG_EN
            acc        <= acc_nxt;
            idx        <= idx_nxt;
`endif
        end
    end

    assign bus.mux_sel   = mux_sel_r;
    assign bus.sh_sample = (state == ST_SETTLE);
    assign bus.sar_ena   = (state == ST_CONVERT);
    assign bus.res_valid = (state == ST_OUTPUT);
    assign bus.res_ch    = res_ch_r;
    assign bus.res_data  = res_data_r;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.err       = err_r;

endmodule
